nqueen_solver: RTL

Self-contained, parametrised N-queens search engine: depth-first backtracking with an internal position stack, conflict checking against one previously placed row per cycle, and streaming of each complete solution as one-hot row beats over a valid/ready bus. It generalises the fixed 8×8 datapath/controller pair to any board size and owns its own controller. It optionally enumerates every solution instead of stopping at the first. It sits between a start/done host handshake and a downstream solution consumer.

---
 rtl/nqueen_pkg.sv | 21 ++
 rtl/nqueen_conflict_check.sv | 21 ++
 rtl/nqueen_solver.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/nqueen_pkg.sv
// Shared types and helpers for the N-queens search engine.
package nqueen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    PLACE,
    NEXT,
    BACKTRACK,
    EMIT,
    DONE
  } state_t;

  localparam int MAX_N = 16;

  // Row/column index width; never below one bit so N=2 still has a real index.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nqueen_conflict_check.sv
// Combinational attack test between two queens: same column or same diagonal.
module nqueen_conflict_check #(
  parameter int W = 3
) (
  input  logic [W-1:0] row1,
  input  logic [W-1:0] col1,
  input  logic [W-1:0] row2,
  input  logic [W-1:0] col2,
  output logic         conflict
);

  logic [W:0] row_diff;
  logic [W:0] col_diff;

  always_comb begin
    row_diff = (row1 >= row2) ? ({1'b0, row1} - {1'b0, row2}) : ({1'b0, row2} - {1'b0, row1});
    col_diff = (col1 >= col2) ? ({1'b0, col1} - {1'b0, col2}) : ({1'b0, col2} - {1'b0, col1});
    conflict = (col1 == col2) || (row_diff == col_diff);
  end

endmodule

// File: rtl/nqueen_solver.sv
// Depth-first N-queens search streaming each solution as one-hot row beats.
// Define NQUEEN_ALL_SOLUTIONS_EN to enumerate every solution instead of stopping at the first.
module nqueen_solver
  import nqueen_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int COUNT_W = 16,
  localparam int W       = idx_w(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_row,
  output logic [N-1:0]       out_bus,
  output logic               out_last,
  output logic [COUNT_W-1:0] sol_count
);

  localparam logic [N-1:0] BUS_ONE  = N'(1);
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [W:0]   LAST_D   = (W + 1)'(N - 1);

  state_t             state_q, state_d;
  logic [W:0]         d_q, d_d;
  logic [W-1:0]       cand_q, cand_d;
  logic [W-1:0]       k_q, k_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       col_q [N];
  logic [W-1:0]       col_d [N];
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               out_valid_q, out_valid_d;
  logic [W-1:0]       out_row_q, out_row_d;
  logic [N-1:0]       out_bus_q, out_bus_d;
  logic               out_last_q, out_last_d;
  logic [COUNT_W-1:0] sol_count_q, sol_count_d;

  logic [W-1:0]       d_idx;
  logic [W-1:0]       b_nxt;
  logic               conflict;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // d never exceeds N-1 in the states that index the stack with it.
  assign d_idx = d_q[W-1:0];
  assign b_nxt = b_q + 1'b1;

  nqueen_conflict_check #(.W(W)) u_conflict (
    .row1     (d_idx),
    .col1     (cand_q),
    .row2     (k_q),
    .col2     (col_q[k_q]),
    .conflict (conflict)
  );

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    cand_d      = cand_q;
    k_d         = k_q;
    b_d         = b_q;
    col_d       = col_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_bus_d   = out_bus_q;
    out_last_d  = out_last_q;
    sol_count_d = sol_count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          d_d         = '0;
          cand_d      = '0;
          k_d         = '0;
          sol_count_d = '0;
          busy_d      = 1'b1;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if ({1'b0, k_q} == d_q) state_d = PLACE;
        else if (conflict)      state_d = NEXT;
        else                    k_d     = k_q + 1'b1;
      end
      PLACE: begin
        col_d[d_idx] = cand_q;
        d_d          = d_q + 1'b1;
        if (d_q == LAST_D) begin
          // Row 0 was placed in an earlier cycle, so its column is already in the stack.
          b_d         = '0;
          out_valid_d = 1'b1;
          out_row_d   = '0;
          out_bus_d   = BUS_ONE << col_q[0];
          out_last_d  = 1'b0;
          state_d     = EMIT;
        end else begin
          cand_d  = '0;
          k_d     = '0;
          state_d = CHECK;
        end
      end
      NEXT: begin
        if (cand_q == LAST_IDX) begin
          state_d = BACKTRACK;
        end else begin
          cand_d  = cand_q + 1'b1;
          k_d     = '0;
          state_d = CHECK;
        end
      end
      BACKTRACK: begin
        if (d_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          d_d     = d_q - 1'b1;
          cand_d  = col_q[d_idx - 1'b1];
          state_d = NEXT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (b_q == LAST_IDX) begin
            sol_count_d = sat_inc(sol_count_q);
            out_valid_d = 1'b0;
            out_row_d   = '0;
            out_bus_d   = '0;
            out_last_d  = 1'b0;
`ifdef NQUEEN_ALL_SOLUTIONS_EN
            d_d         = LAST_D;
            cand_d      = col_q[LAST_IDX];
            state_d     = NEXT;
`else
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = DONE;
`endif
          end else begin
            b_d        = b_nxt;
            out_row_d  = b_nxt;
            out_bus_d  = BUS_ONE << col_q[b_nxt];
            out_last_d = (b_nxt == LAST_IDX);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      d_q         <= '0;
      cand_q      <= '0;
      k_q         <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_bus_q   <= '0;
      out_last_q  <= 1'b0;
      sol_count_q <= '0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      cand_q      <= cand_d;
      k_q         <= k_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_bus_q   <= out_bus_d;
      out_last_q  <= out_last_d;
      sol_count_q <= sol_count_d;
    end
  end

  // The column stack is pure data; it is always written before being read.
  always_ff @(posedge clk) begin
    col_q <= col_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_bus   = out_bus_q;
  assign out_last  = out_last_q;
  assign sol_count = sol_count_q;

endmodule
